// File: rtl/neo_light_pkg.sv
// Shared types and BCD limits for the Neo-Light scheduling stage.
package neo_light_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    ON,
    RAMP_DOWN
  } state_t;

  localparam logic [7:0] BCD_MAX_HH = 8'h23;
  localparam logic [7:0] BCD_MAX_MM = 8'h59;

endpackage

// File: rtl/bcd_hhmm_check.sv
// Combinational validity check of a BCD {HH,MM} time of day.
module bcd_hhmm_check
  import neo_light_pkg::*;
(
  input  logic [15:0] i_hhmm,
  output logic        o_valid
);

  logic w_digits_ok;
  logic w_hh_ok;
  logic w_mm_ok;

  assign w_digits_ok = (i_hhmm[15:12] <= 4'd9) && (i_hhmm[11:8] <= 4'd9) &&
                       (i_hhmm[7:4]   <= 4'd9) && (i_hhmm[3:0]  <= 4'd9);
  assign w_hh_ok     = (i_hhmm[15:8] <= BCD_MAX_HH);
  assign w_mm_ok     = (i_hhmm[7:0]  <= BCD_MAX_MM);
  assign o_valid     = w_digits_ok && w_hh_ok && w_mm_ok;

endmodule

// File: rtl/light_scheduler.sv
// Daily ON/OFF brightness scheduler driven by the BCD wall-clock time;
// ramps the LED level up at the ON time and down at the OFF time.
module light_scheduler
  import neo_light_pkg::*;
#(
  parameter int MAX_LEVEL = 255,
  parameter int STEP      = 4
) (
  input  logic        clk,
  input  logic        init,
  input  logic [23:0] hora,
  input  logic [15:0] on_time,
  input  logic [15:0] off_time,
  input  logic        cfg_load,
  input  logic        force_off,
  output logic [7:0]  level,
  output logic        light_on,
  output logic        sched_valid,
  output logic        cfg_err
);

  localparam logic [8:0] LP_MAX  = 9'(MAX_LEVEL);
  localparam logic [8:0] LP_STEP = 9'(STEP);

  logic [23:0] r_hora_q;
  logic        r_primed;
  logic [15:0] r_on_time;
  logic [15:0] r_off_time;
  logic        r_sched_valid;
  logic        r_cfg_err;
  logic [7:0]  r_level;
  logic        r_light_on;
  state_t      r_state;

  logic        w_on_ok;
  logic        w_off_ok;
  logic        w_cfg_ok;
  logic        w_tick;
  logic        w_on_hit;
  logic        w_off_hit;
  logic [8:0]  w_up;
  logic signed [8:0] w_dn;
  logic [7:0]  w_up_lvl;
  logic [7:0]  w_dn_lvl;

  bcd_hhmm_check u_on_check (
    .i_hhmm  (on_time),
    .o_valid (w_on_ok)
  );

  bcd_hhmm_check u_off_check (
    .i_hhmm  (off_time),
    .o_valid (w_off_ok)
  );

  assign w_cfg_ok = w_on_ok && w_off_ok && (on_time != off_time);

  // First sample after reset only primes the comparator and never ticks.
  assign w_tick    = r_primed && (hora != r_hora_q);
  assign w_on_hit  = w_tick && r_sched_valid &&
                     (hora[23:8] == r_on_time) && (hora[7:0] == 8'h00);
  assign w_off_hit = w_tick && r_sched_valid &&
                     (hora[23:8] == r_off_time) && (hora[7:0] == 8'h00);

  assign w_up     = {1'b0, r_level} + LP_STEP;
  assign w_up_lvl = (w_up >= LP_MAX) ? LP_MAX[7:0] : w_up[7:0];
  assign w_dn     = $signed({1'b0, r_level}) - $signed(LP_STEP);
  assign w_dn_lvl = (w_dn[8] || (w_dn == 9'sd0)) ? 8'd0 : w_dn[7:0];

  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      r_hora_q <= 24'h000000;
      r_primed <= 1'b0;
    end else begin
      r_hora_q <= hora;
      r_primed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      r_on_time     <= 16'h0000;
      r_off_time    <= 16'h0000;
      r_sched_valid <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_cfg_err <= cfg_load && !w_cfg_ok;
      if (cfg_load && w_cfg_ok) begin
        r_on_time     <= on_time;
        r_off_time    <= off_time;
        r_sched_valid <= 1'b1;
      end
    end
  end

  // force_off overrides everything; otherwise the level only moves on ticks.
  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      r_state    <= IDLE;
      r_level    <= 8'd0;
      r_light_on <= 1'b0;
    end else if (force_off && (r_state != IDLE)) begin
      if (w_tick) begin
        r_level    <= w_dn_lvl;
        r_light_on <= (w_dn_lvl != 8'd0);
        r_state    <= (w_dn_lvl == 8'd0) ? IDLE : RAMP_DOWN;
      end else begin
        r_state <= RAMP_DOWN;
      end
    end else if (w_tick) begin
      case (r_state)
        IDLE: begin
          if (w_on_hit && !force_off) begin
            r_level    <= w_up_lvl;
            r_light_on <= 1'b1;
            r_state    <= (w_up_lvl == LP_MAX[7:0]) ? ON : RAMP_UP;
          end
        end
        RAMP_UP, ON: begin
          if (w_off_hit) begin
            r_level    <= w_dn_lvl;
            r_light_on <= (w_dn_lvl != 8'd0);
            r_state    <= (w_dn_lvl == 8'd0) ? IDLE : RAMP_DOWN;
          end else if (r_state == RAMP_UP) begin
            r_level    <= w_up_lvl;
            r_light_on <= 1'b1;
            r_state    <= (w_up_lvl == LP_MAX[7:0]) ? ON : RAMP_UP;
          end
        end
        RAMP_DOWN: begin
          if (w_on_hit) begin
            r_level    <= w_up_lvl;
            r_light_on <= 1'b1;
            r_state    <= (w_up_lvl == LP_MAX[7:0]) ? ON : RAMP_UP;
          end else begin
            r_level    <= w_dn_lvl;
            r_light_on <= (w_dn_lvl != 8'd0);
            r_state    <= (w_dn_lvl == 8'd0) ? IDLE : RAMP_DOWN;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign level       = r_level;
  assign light_on    = r_light_on;
  assign sched_valid = r_sched_valid;
  assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_light_scheduler.sv
// Directed testbench for light_scheduler with hand-computed expectations.
module tb_light_scheduler;
  import neo_light_pkg::*;

  logic        clk;
  logic        init;
  logic [23:0] hora;
  logic [15:0] on_time;
  logic [15:0] off_time;
  logic        cfg_load;
  logic        force_off;
  logic [7:0]  level;
  logic        light_on;
  logic        sched_valid;
  logic        cfg_err;

  int assertCount = 0;
  int failCount   = 0;

  light_scheduler dut (
    .clk         (clk),
    .init        (init),
    .hora        (hora),
    .on_time     (on_time),
    .off_time    (off_time),
    .cfg_load    (cfg_load),
    .force_off   (force_off),
    .level       (level),
    .light_on    (light_on),
    .sched_valid (sched_valid),
    .cfg_err     (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One tick: hora changes at a falling edge, the next rising edge sees it.
  task automatic applyStimulus(input logic [23:0] t);
    @(negedge clk);
    hora = t;
    @(negedge clk);
  endtask

  task automatic runTicks(input logic [23:0] base, input int n);
    for (int k = 1; k <= n; k++) applyStimulus(base + 24'(k));
  endtask

  task automatic loadCfg(input logic [15:0] onT, input logic [15:0] offT);
    @(negedge clk);
    on_time  = onT;
    off_time = offT;
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL timeout: observed no finish expected finish");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    init      = 1'b0;
    hora      = 24'h000000;
    on_time   = 16'h0000;
    off_time  = 16'h0000;
    cfg_load  = 1'b0;
    force_off = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_level", 32'(level), 32'd0);
    checkOutput("reset_light_on", 32'(light_on), 32'd0);
    checkOutput("reset_sched_valid", 32'(sched_valid), 32'd0);
    checkOutput("reset_cfg_err", 32'(cfg_err), 32'd0);
    init = 1'b1;
    repeat (2) @(negedge clk);

    // Rejected configurations.
    loadCfg(16'h0700, 16'h0700);
    checkOutput("equal_times_cfg_err", 32'(cfg_err), 32'd1);
    checkOutput("equal_times_sched_valid", 32'(sched_valid), 32'd0);
    @(negedge clk);
    checkOutput("cfg_err_one_cycle", 32'(cfg_err), 32'd0);
    loadCfg(16'h2460, 16'h2200);
    checkOutput("bad_bcd_cfg_err", 32'(cfg_err), 32'd1);
    checkOutput("bad_bcd_sched_valid", 32'(sched_valid), 32'd0);
    loadCfg(16'h0700, 16'h2200);
    checkOutput("good_cfg_err", 32'(cfg_err), 32'd0);
    checkOutput("good_sched_valid", 32'(sched_valid), 32'd1);

    // Full ramp up.
    applyStimulus(24'h065959);
    checkOutput("pre_on_level", 32'(level), 32'd0);
    applyStimulus(24'h070000);
    checkOutput("on_hit_level", 32'(level), 32'd4);
    checkOutput("on_hit_light_on", 32'(light_on), 32'd1);
    runTicks(24'h070000, 62);
    checkOutput("ramp_tick63_level", 32'(level), 32'd252);
    checkOutput("ramp_tick63_state", 32'(dut.r_state), 32'(RAMP_UP));
    applyStimulus(24'h07003F);
    checkOutput("ramp_sat_level", 32'(level), 32'd255);
    checkOutput("ramp_sat_state", 32'(dut.r_state), 32'(ON));

    // Off hit from ON.
    applyStimulus(24'h220000);
    checkOutput("off_hit_level", 32'(level), 32'd251);
    checkOutput("off_hit_state", 32'(dut.r_state), 32'(RAMP_DOWN));
    runTicks(24'h220000, 62);
    checkOutput("down_tick63_level", 32'(level), 32'd3);
    applyStimulus(24'h22003F);
    checkOutput("down_end_level", 32'(level), 32'd0);
    checkOutput("down_end_light_on", 32'(light_on), 32'd0);
    checkOutput("down_end_state", 32'(dut.r_state), 32'(IDLE));

    // Off hit while ramping up.
    applyStimulus(24'h070000);
    runTicks(24'h070000, 9);
    checkOutput("partial_up_level", 32'(level), 32'd40);
    applyStimulus(24'h220000);
    checkOutput("off_in_ramp_level", 32'(level), 32'd36);
    checkOutput("off_in_ramp_state", 32'(dut.r_state), 32'(RAMP_DOWN));
    runTicks(24'h220000, 9);
    checkOutput("off_in_ramp_end", 32'(level), 32'd0);

    // Time set jumping over the ON minute.
    applyStimulus(24'h065900);
    applyStimulus(24'h070130);
    checkOutput("jump_no_hit_level", 32'(level), 32'd0);
    checkOutput("jump_no_hit_state", 32'(dut.r_state), 32'(IDLE));

    // force_off.
    applyStimulus(24'h070000);
    runTicks(24'h070000, 24);
    checkOutput("pre_force_level", 32'(level), 32'd100);
    @(negedge clk);
    force_off = 1'b1;
    @(negedge clk);
    checkOutput("force_hold_level", 32'(level), 32'd100);
    checkOutput("force_state", 32'(dut.r_state), 32'(RAMP_DOWN));
    applyStimulus(24'h080001);
    checkOutput("force_step1", 32'(level), 32'd96);
    applyStimulus(24'h080002);
    checkOutput("force_step2", 32'(level), 32'd92);
    applyStimulus(24'h070000);
    checkOutput("force_on_ignored_level", 32'(level), 32'd88);
    checkOutput("force_on_ignored_state", 32'(dut.r_state), 32'(RAMP_DOWN));
    runTicks(24'h080100, 22);
    checkOutput("force_end_level", 32'(level), 32'd0);
    checkOutput("force_end_state", 32'(dut.r_state), 32'(IDLE));
    applyStimulus(24'h065959);
    applyStimulus(24'h070000);
    checkOutput("force_idle_on_ignored", 32'(level), 32'd0);
    force_off = 1'b0;

    // Asynchronous reset in the middle of a ramp.
    applyStimulus(24'h065959);
    applyStimulus(24'h070000);
    runTicks(24'h070000, 31);
    checkOutput("pre_reset_level", 32'(level), 32'd128);
    @(negedge clk);
    #2;
    init = 1'b0;
    hora = 24'h070000;
    #1;
    checkOutput("async_reset_level", 32'(level), 32'd0);
    checkOutput("async_reset_light_on", 32'(light_on), 32'd0);
    checkOutput("async_reset_sched_valid", 32'(sched_valid), 32'd0);
    @(negedge clk);
    init = 1'b1;
    #1;
    checkOutput("first_sample_no_tick", 32'(dut.w_tick), 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("post_reset_level", 32'(level), 32'd0);
    checkOutput("post_reset_state", 32'(dut.r_state), 32'(IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
